// File: rtl/sprite_pkg.sv
// Shared types, screen geometry and the colour palette for the sprite layer.
//   rgb444_t  : packed 4:4:4 colour
//   H_ACTIVE  : visible pixels per line
//   V_ACTIVE  : visible lines per frame
//   palette() : combinational 16-entry index -> RGB444 lookup
package sprite_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    function automatic rgb444_t palette(input logic [3:0] idx);
        rgb444_t c;
        case (idx)
            4'd0:    c = 12'h000;
            4'd1:    c = 12'h00A;
            4'd2:    c = 12'h0A0;
            4'd3:    c = 12'h0AA;
            4'd4:    c = 12'hA00;
            4'd5:    c = 12'hF80;
            4'd6:    c = 12'hA50;
            4'd7:    c = 12'hAAA;
            4'd8:    c = 12'h555;
            4'd9:    c = 12'h55F;
            4'd10:   c = 12'h5F5;
            4'd11:   c = 12'h5FF;
            4'd12:   c = 12'hF55;
            4'd13:   c = 12'hF5F;
            4'd14:   c = 12'hFF5;
            4'd15:   c = 12'hFFF;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sprite_layer_rom.sv
// Synchronous sprite pixel ROM, one palette index (4 bits) per word,
// one-cycle read latency.
//   vga_clk : pixel clock
//   reset_n : asynchronous active-low reset (clears the read register)
//   addr_i  : word address, frame-major then row-major
//   data_o  : palette index registered from addr_i on the previous edge
module sprite_layer_rom #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [3:0]        data_o
);

    logic [3:0] data_q;
    logic [3:0] data_d;

    // Image content is a fixed arithmetic pattern: index 5 at word 0 of
    // frame 0, a different colour at word 0 of every frame, and scattered
    // transparent (0) pixels inside each frame.
    function automatic logic [3:0] pixel_at(input logic [ADDR_W-1:0] a);
        logic [31:0] a32;
        logic [31:0] v;
        a32 = 32'(a);
        v   = a32 * 32'd7 + (a32 >> 5) * 32'd3 + (a32 >> 10) * 32'd5 + 32'd5;
        return 4'(v);
    endfunction

    // Content lookup; words beyond the stored frames read as transparent.
    always_comb begin
        data_d = 4'd0;
        if (32'(addr_i) < DEPTH) begin
            data_d = pixel_at(addr_i);
        end else begin
            data_d = 4'd0;
        end
    end

    // Read register giving the one-cycle latency.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= 4'd0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/sprite_layer.sv
// Animated, scalable sprite composited over a background video stream.
// Latency two pixel clocks, one pixel per clock.
//   vga_clk, reset_n            : pixel clock, asynchronous active-low reset
//   DrawX, DrawY, blank         : current pixel coordinate, 1 = active video
//   pos_x, pos_y, pos_valid     : requested top-left corner + load strobe
//   anim_en                     : 1 = animation advances at frame ticks
//   bg_red, bg_green, bg_blue   : background pixel for the same coordinate
//   red, green, blue, hit       : registered composited pixel, opaque flag
module sprite_layer
    import sprite_pkg::*;
#(
    parameter int SPR_W           = 32,
    parameter int SPR_H           = 32,
    parameter int SCALE_LOG2      = 0,
    parameter int NUM_FRAMES      = 4,
    parameter int FRAME_PERIOD    = 8,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic       pos_valid,
    input  logic       anim_en,
    input  logic [3:0] bg_red,
    input  logic [3:0] bg_green,
    input  logic [3:0] bg_blue,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hit
);

    localparam int          DEPTH   = NUM_FRAMES * SPR_W * SPR_H;
    localparam int          ADDR_W  = $clog2(DEPTH);
    localparam int          FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int          TICK_W  = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [10:0] BOX_W   = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0] BOX_H   = 11'(SPR_H << SCALE_LOG2);

    // Position and animation state
    logic [9:0]         act_x_q, act_x_d, act_y_q, act_y_d;
    logic [9:0]         pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic               pend_flag_q, pend_flag_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [FRAME_W-1:0] anim_frame_q, anim_frame_d;

    // Pipeline
    logic               in_box_q, blank_q;
    rgb444_t            bg_q, bg_s;
    rgb444_t            out_q, out_d;
    logic               hit_q, hit_d;

    logic               frame_tick_s;
    logic               in_box_s;
    logic [10:0]        dx_s, dy_s, ax_s, ay_s, rel_x_s, rel_y_s;
    logic [ADDR_W-1:0]  addr_s;
    logic [3:0]         rom_data_s;

    assign frame_tick_s = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));
    assign bg_s         = '{r: bg_red, g: bg_green, b: bg_blue};

    // Position double-buffer: requests wait for the frame tick so the
    // sprite never moves mid-frame; a request on the tick itself is direct.
    always_comb begin
        act_x_d     = act_x_q;
        act_y_d     = act_y_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        pend_flag_d = pend_flag_q;
        if (frame_tick_s && pos_valid) begin
            act_x_d     = pos_x;
            act_y_d     = pos_y;
            pend_flag_d = 1'b0;
        end else if (frame_tick_s && pend_flag_q) begin
            act_x_d     = pend_x_q;
            act_y_d     = pend_y_q;
            pend_flag_d = 1'b0;
        end else if (pos_valid) begin
            pend_x_d    = pos_x;
            pend_y_d    = pos_y;
            pend_flag_d = 1'b1;
        end else begin
            pend_flag_d = pend_flag_q;
        end
    end

    // Animation: FRAME_PERIOD enabled ticks per animation step.
    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        anim_frame_d = anim_frame_q;
        if (frame_tick_s && anim_en) begin
            if (tick_cnt_q == TICK_W'(FRAME_PERIOD - 1)) begin
                tick_cnt_d = '0;
                if (anim_frame_q == FRAME_W'(NUM_FRAMES - 1)) begin
                    anim_frame_d = '0;
                end else begin
                    anim_frame_d = anim_frame_q + FRAME_W'(1);
                end
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end else begin
            tick_cnt_d = tick_cnt_q;
        end
    end

    // Box test and ROM address. 11-bit compares keep pos+size from wrapping;
    // the visible-area limits stop a box near the edge spilling over.
    always_comb begin
        dx_s     = {1'b0, DrawX};
        dy_s     = {1'b0, DrawY};
        ax_s     = {1'b0, act_x_q};
        ay_s     = {1'b0, act_y_q};
        rel_x_s  = dx_s - ax_s;
        rel_y_s  = dy_s - ay_s;
        in_box_s = (dx_s >= ax_s) && (dx_s < ax_s + BOX_W) && (dx_s < 11'(H_ACTIVE))
                && (dy_s >= ay_s) && (dy_s < ay_s + BOX_H) && (dy_s < 11'(V_ACTIVE));
        addr_s   = '0;
        if (in_box_s) begin
            addr_s = ADDR_W'(anim_frame_q) * ADDR_W'(SPR_W * SPR_H)
                   + ADDR_W'(rel_y_s >> SCALE_LOG2) * ADDR_W'(SPR_W)
                   + ADDR_W'(rel_x_s >> SCALE_LOG2);
        end else begin
            addr_s = '0;
        end
    end

    // Position and animation registers.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            act_x_q      <= 10'd0;
            act_y_q      <= 10'd0;
            pend_x_q     <= 10'd0;
            pend_y_q     <= 10'd0;
            pend_flag_q  <= 1'b0;
            tick_cnt_q   <= '0;
            anim_frame_q <= '0;
        end else begin
            act_x_q      <= act_x_d;
            act_y_q      <= act_y_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_flag_q  <= pend_flag_d;
            tick_cnt_q   <= tick_cnt_d;
            anim_frame_q <= anim_frame_d;
        end
    end

    sprite_layer_rom #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rom (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .addr_i  (addr_s),
        .data_o  (rom_data_s)
    );

    // Stage 1: delay box/blank/background to line up with ROM data.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            in_box_q <= 1'b0;
            blank_q  <= 1'b0;
            bg_q     <= 12'h000;
        end else begin
            in_box_q <= in_box_s;
            blank_q  <= blank;
            bg_q     <= bg_s;
        end
    end

    // Compositing: blanking forces black, opaque sprite pixels win over bg.
    always_comb begin
        out_d = bg_q;
        hit_d = 1'b0;
        if (!blank_q) begin
            out_d = 12'h000;
            hit_d = 1'b0;
        end else if (in_box_q && (rom_data_s != 4'(TRANSPARENT_IDX))) begin
            out_d = palette(rom_data_s);
            hit_d = 1'b1;
        end else begin
            out_d = bg_q;
            hit_d = 1'b0;
        end
    end

    // Stage 2: output registers.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= 12'h000;
            hit_q <= 1'b0;
        end else begin
            out_q <= out_d;
            hit_q <= hit_d;
        end
    end

    assign red   = out_q.r;
    assign green = out_q.g;
    assign blue  = out_q.b;
    assign hit   = hit_q;

endmodule

// File: tb/tb_sprite_layer.sv
module tb_sprite_layer;

    localparam int W  = 32;
    localparam int H  = 32;
    localparam int SL = 1;
    localparam int NF = 4;
    localparam int FP = 2;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic [9:0] DrawX, DrawY, pos_x, pos_y;
    logic       blank, pos_valid, anim_en;
    logic [3:0] bg_red, bg_green, bg_blue;
    logic [3:0] red, green, blue;
    logic       hit;

    int checks   = 0;
    int failures = 0;

    logic [11:0] pal [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hF80,
                              12'hA50, 12'hAAA, 12'h555, 12'h55F, 12'h5F5, 12'h5FF,
                              12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

    // Reference state
    int ax, ay, px, py, pflag, tcnt, aframe;
    logic [12:0] pipe1, pipe2;

    sprite_layer #(
        .SPR_W(W), .SPR_H(H), .SCALE_LOG2(SL), .NUM_FRAMES(NF),
        .FRAME_PERIOD(FP), .TRANSPARENT_IDX(0)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
        .anim_en(anim_en), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .red(red), .green(green), .blue(blue), .hit(hit)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [3:0] rom_idx(input int a);
        int v;
        v = a * 7 + (a / 32) * 3 + (a / 1024) * 5 + 5;
        return 4'(v % 16);
    endfunction

    function automatic logic [12:0] model_pixel();
        int x, y, bw, bh;
        logic [3:0] idx;
        x  = int'(DrawX);
        y  = int'(DrawY);
        bw = W * (2 ** SL);
        bh = H * (2 ** SL);
        if (!blank) return 13'd0;
        if (x >= ax && x < ax + bw && x < 640 && y >= ay && y < ay + bh && y < 480) begin
            idx = rom_idx(aframe * W * H + ((y - ay) / (2 ** SL)) * W + (x - ax) / (2 ** SL));
            if (idx != 4'd0) return {1'b1, pal[idx]};
        end
        return {1'b0, bg_red, bg_green, bg_blue};
    endfunction

    task automatic model_update();
        bit tick;
        tick = (DrawX == 10'd0) && (DrawY == 10'd480);
        if (tick && pos_valid) begin
            ax = int'(pos_x); ay = int'(pos_y); pflag = 0;
        end else if (tick && pflag != 0) begin
            ax = px; ay = py; pflag = 0;
        end else if (pos_valid) begin
            px = int'(pos_x); py = int'(pos_y); pflag = 1;
        end
        if (tick && anim_en) begin
            tcnt = tcnt + 1;
            if (tcnt == FP) begin
                tcnt   = 0;
                aframe = (aframe + 1) % NF;
            end
        end
    endtask

    task automatic model_reset();
        ax = 0; ay = 0; px = 0; py = 0; pflag = 0; tcnt = 0; aframe = 0;
        pipe1 = 13'd0; pipe2 = 13'd0;
    endtask

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got hit/rgb=%h expected %h (DrawX=%0d DrawY=%0d t=%0t)",
                     name, act, exp, DrawX, DrawY, $time);
        end
    endtask

    // One pixel clock: predict, clock, then compare against the pixel from two clocks ago.
    task automatic step();
        logic [12:0] e;
        e = model_pixel();
        @(posedge vga_clk);
        model_update();
        pipe2 = pipe1;
        pipe1 = e;
        #1;
        check("pixel", {hit, red, green, blue}, pipe2);
        @(negedge vga_clk);
    endtask

    task automatic idle();
        DrawX = 10'd700; DrawY = 10'd0; blank = 1'b0; pos_valid = 1'b0;
    endtask

    task automatic probe(input int x, input int y, output logic [12:0] r);
        DrawX = 10'(x); DrawY = 10'(y); blank = 1'b1; pos_valid = 1'b0;
        step();
        idle();
        step();
        r = {hit, red, green, blue};
    endtask

    task automatic load(input int x, input int y);
        DrawX = 10'd5; DrawY = 10'd100; blank = 1'b0;
        pos_x = 10'(x); pos_y = 10'(y); pos_valid = 1'b1;
        step();
        pos_valid = 1'b0;
    endtask

    task automatic tick(input bit pv, input int x, input int y);
        DrawX = 10'd0; DrawY = 10'd480; blank = 1'b0;
        pos_x = 10'(x); pos_y = 10'(y); pos_valid = pv;
        step();
        pos_valid = 1'b0;
    endtask

    localparam logic [12:0] BG  = 13'h0123;
    localparam logic [12:0] P5  = {1'b1, 12'hF80};

    initial begin
        logic [12:0] r;
        int exp_idx [9] = '{5, 5, 10, 10, 15, 15, 4, 4, 5};
        reset_n = 1'b0;
        idle();
        pos_x = 10'd0; pos_y = 10'd0; anim_en = 1'b0;
        bg_red = 4'h1; bg_green = 4'h2; bg_blue = 4'h3;
        model_reset();
        #1;
        check("reset_state", {hit, red, green, blue}, 13'd0);
        @(posedge vga_clk); @(posedge vga_clk); @(negedge vga_clk);
        reset_n = 1'b1;
        step();

        // Basic hit and scaling at (100,50)
        load(100, 50); tick(1'b0, 0, 0);
        probe(100, 50, r); check("hit_origin", r, P5);
        probe(99, 50, r);  check("left_of_box", r, BG);
        probe(101, 51, r); check("scaled_pixel", r, P5);

        // Pending position waits for the frame tick
        load(200, 200);
        probe(100, 50, r);  check("old_pos_held", r, P5);
        probe(200, 200, r); check("new_pos_early", r, BG);
        tick(1'b0, 0, 0);
        probe(200, 200, r); check("new_pos_after_tick", r, P5);
        probe(100, 50, r);  check("old_pos_gone", r, BG);

        // Strobe on the tick loads directly; flag stays clear
        tick(1'b1, 10, 10);
        probe(10, 10, r); check("direct_load", r, P5);
        tick(1'b0, 0, 0);
        probe(10, 10, r); check("no_stale_pending", r, P5);

        // Right/bottom edge clipping
        load(620, 470); tick(1'b0, 0, 0);
        probe(620, 470, r); check("edge_origin", r, P5);
        probe(630, 475, r); check("edge_inner", r, {1'b1, 12'hFF5});
        probe(639, 479, r); check("edge_transparent", r, BG);
        probe(11, 0, r);    check("no_wrap_x", r, BG);
        probe(0, 21, r);    check("no_wrap_y", r, BG);

        // Animation sequence: frame colour probed before each tick
        tick(1'b1, 10, 10);
        anim_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            probe(10, 10, r);
            check("anim_seq", r, {1'b1, pal[exp_idx[k]]});
            tick(1'b0, 0, 0);
        end
        anim_en = 1'b0;
        tick(1'b0, 0, 0);
        probe(10, 10, r); check("anim_hold", r, P5);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int rr, t;
            rr = int'($urandom_range(0, 99));
            bg_red = 4'($urandom); bg_green = 4'($urandom); bg_blue = 4'($urandom);
            anim_en   = ($urandom_range(0, 3) != 0);
            pos_valid = ($urandom_range(0, 29) == 0);
            pos_x = 10'($urandom_range(0, 700));
            pos_y = 10'($urandom_range(0, 520));
            blank = ($urandom_range(0, 9) != 0);
            if (rr < 3) begin
                DrawX = 10'd0; DrawY = 10'd480;
            end else if (rr < 75) begin
                t = ax + int'($urandom_range(0, 80)) - 8; if (t < 0) t = 0;
                DrawX = 10'(t);
                t = ay + int'($urandom_range(0, 80)) - 8; if (t < 0) t = 0;
                DrawY = 10'(t);
            end else begin
                DrawX = 10'($urandom_range(0, 799));
                DrawY = 10'($urandom_range(0, 524));
            end
            step();
        end

        // Asynchronous reset mid-line
        bg_red = 4'h1; bg_green = 4'h2; bg_blue = 4'h3; anim_en = 1'b0;
        tick(1'b1, 10, 10);
        probe(10, 10, r);
        DrawX = 10'd300; DrawY = 10'd40; blank = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {hit, red, green, blue}, 13'd0);
        model_reset();
        @(posedge vga_clk); @(posedge vga_clk); @(negedge vga_clk);
        reset_n = 1'b1;
        probe(0, 0, r);     check("post_reset_origin", r, P5);
        probe(100, 50, r);  check("post_reset_bg", r, BG);
        probe(5, 5, r);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
